// File: rtl/multdiv_sequencer_if.sv
// multdiv_sequencer_if: processor/core bus of the mult/div sequencer; master drives starts, operands and core results, slave returns operands, counter, busy and result
interface multdiv_sequencer_if;
  logic ctrl_MULT;
  logic ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] mult_product;
  logic mult_overflow;
  logic [31:0] div_quotient;
  logic div_error;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] counter;
  logic op_is_div;
  logic busy;
  logic [31:0] data_result;
  logic data_exception;
  logic data_resultRDY;
  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
           mult_product, mult_overflow, div_quotient, div_error,
    input  op_a, op_b, counter, op_is_div, busy, data_result, data_exception, data_resultRDY
  );
  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
           mult_product, mult_overflow, div_quotient, div_error,
    output op_a, op_b, counter, op_is_div, busy, data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: latches operands on ctrl_MULT/ctrl_DIV, runs the shared core counter, captures core result/error at the final iteration and pulses data_resultRDY; ports clk, reset, bus (slave)
module multdiv_sequencer #(
  parameter int MULT_CYCLES = 17,
  parameter int DIV_CYCLES  = 33
) (
  input logic clk,
  input logic reset,
  multdiv_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, MRUN, DRUN, DZ, DONE} state_t;
  localparam logic [31:0] MC = 32'(MULT_CYCLES);
  localparam logic [31:0] DC = 32'(DIV_CYCLES);
  state_t state;
  logic start;
  logic last;
  assign start = bus.ctrl_MULT | bus.ctrl_DIV;
  assign last = bus.counter == ((state == MRUN) ? MC : DC);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bus.counter <= '0;
      bus.op_a <= '0;
      bus.op_b <= '0;
      bus.data_result <= '0;
      bus.data_exception <= 1'b0;
      bus.data_resultRDY <= 1'b0;
      bus.busy <= 1'b0;
      bus.op_is_div <= 1'b0;
    end else if (start) begin
      bus.op_a <= bus.data_operandA;
      bus.op_b <= bus.data_operandB;
      bus.counter <= '0;
      bus.data_resultRDY <= 1'b0;
      bus.busy <= 1'b1;
      bus.op_is_div <= !bus.ctrl_MULT;
      state <= bus.ctrl_MULT ? MRUN : (bus.data_operandB == '0 ? DZ : DRUN);
    end else begin
      bus.data_resultRDY <= 1'b0;
      case (state)
        MRUN, DRUN: begin
          if (last) begin
            bus.data_result <= (state == MRUN) ? bus.mult_product : bus.div_quotient;
            bus.data_exception <= (state == MRUN) ? bus.mult_overflow : bus.div_error;
            bus.counter <= '0;
            bus.busy <= 1'b0;
            bus.data_resultRDY <= 1'b1;
            state <= DONE;
          end else begin
            bus.counter <= bus.counter + 32'd1;
          end
        end
        DZ: begin
          bus.data_result <= '0;
          bus.data_exception <= 1'b1;
          bus.busy <= 1'b0;
          bus.data_resultRDY <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed and random starts checked every cycle against a latency-based model of the sequencer
module tb_multdiv_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  multdiv_sequencer_if bus();
  multdiv_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  int vec = 0;
  int miss = 0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    vec++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  function automatic logic [32:0] mul_core(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    return {p != {{32{p[31]}}, p[31:0]}, p[31:0]};
  endfunction
  function automatic logic [32:0] div_core(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] q;
    if (b == '0) return {1'b1, 32'd0};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b1, 32'h80000000};
    q = $signed({{32{a[31]}}, a}) / $signed({{32{b[31]}}, b});
    return {1'b0, q[31:0]};
  endfunction
  logic armed = 1'b0;
  logic act;
  int j, n;
  logic [31:0] ma, mb, mres, junk;
  logic mexc, mdiv;
  logic [32:0] mc, dc;
  assign mc = mul_core(ma, mb);
  assign dc = div_core(ma, mb);
  assign bus.mult_product = bus.counter == 32'd17 ? mc[31:0] : junk;
  assign bus.mult_overflow = bus.counter == 32'd17 ? mc[32] : junk[0];
  assign bus.div_quotient = bus.counter == 32'd33 ? dc[31:0] : ~junk;
  assign bus.div_error = bus.counter == 32'd33 ? dc[32] : junk[1];
  always @(posedge clk) junk <= $urandom;
  always @(posedge clk) begin
    if (reset) begin
      armed <= 1'b1;
      act <= 1'b0;
      j <= 0;
      n <= 0;
      ma <= '0;
      mb <= '0;
      mres <= '0;
      mexc <= 1'b0;
      mdiv <= 1'b0;
    end else if (bus.ctrl_MULT | bus.ctrl_DIV) begin
      act <= 1'b1;
      j <= 1;
      ma <= bus.data_operandA;
      mb <= bus.data_operandB;
      mdiv <= !bus.ctrl_MULT;
      n <= bus.ctrl_MULT ? 17 : (bus.data_operandB == '0 ? 0 : 33);
    end else if (act) begin
      j <= j + 1;
      if (j + 1 == n + 2) begin
        mres <= n == 17 ? mc[31:0] : (n == 33 ? dc[31:0] : 32'd0);
        mexc <= n == 17 ? mc[32] : (n == 33 ? dc[32] : 1'b1);
      end
      if (j + 1 > n + 2) act <= 1'b0;
    end
  end
  logic e_busy, e_rdy;
  logic [31:0] e_cnt;
  assign e_busy = act && j <= n + 1;
  assign e_rdy = act && j == n + 2;
  assign e_cnt = e_busy ? 32'(j - 1) : 32'd0;
  always @(negedge clk) begin
    if (armed) begin
      chk("op_a", bus.op_a, ma);
      chk("op_b", bus.op_b, mb);
      chk("counter", bus.counter, e_cnt);
      chk("op_is_div", 32'(bus.op_is_div), 32'(mdiv));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("rdy", 32'(bus.data_resultRDY), 32'(e_rdy));
      chk("result", bus.data_result, mres);
      chk("exception", 32'(bus.data_exception), 32'(mexc));
    end
  end
  task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    bus.ctrl_MULT = m;
    bus.ctrl_DIV = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clk);
    #1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask
  task automatic wait_rdy(output int lat);
    lat = 1;
    forever begin
      @(negedge clk);
      if (bus.data_resultRDY || lat > 60) break;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  int lat;
  logic [32:0] pin;
  initial begin
    reset = 1'b1;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_result", bus.data_result, 32'd0);
    chk("reset_counter", bus.counter, 32'd0);
    pin = mul_core(32'd7, 32'hFFFFFFFD);
    chk("pin_mul", pin[31:0], 32'hFFFFFFEB);
    pin = div_core(32'd100, 32'd7);
    chk("pin_div", pin[31:0], 32'd14);
    @(posedge clk);
    #1;
    start(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    wait_rdy(lat);
    chk("mul_lat", lat, 19);
    chk("mul_res", bus.data_result, 32'hFFFFFFEB);
    chk("mul_exc", 32'(bus.data_exception), 32'd0);
    @(posedge clk);
    #1;
    start(1'b1, 1'b0, 32'h00010000, 32'h00010000);
    wait_rdy(lat);
    chk("ovf_lat", lat, 19);
    chk("ovf_exc", 32'(bus.data_exception), 32'd1);
    chk("ovf_res", bus.data_result, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_hold", 32'(bus.data_exception), 32'd1);
    start(1'b0, 1'b1, 32'd100, 32'd7);
    wait_rdy(lat);
    chk("div_lat", lat, 35);
    chk("div_res", bus.data_result, 32'd14);
    chk("div_flag", 32'(bus.op_is_div), 32'd1);
    @(posedge clk);
    #1;
    start(1'b0, 1'b1, 32'd5, 32'd0);
    wait_rdy(lat);
    chk("dz_lat", lat, 2);
    chk("dz_res", bus.data_result, 32'd0);
    chk("dz_exc", 32'(bus.data_exception), 32'd1);
    @(posedge clk);
    #1;
    start(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (7) @(posedge clk);
    #1;
    start(1'b0, 1'b1, 32'd100, 32'd7);
    @(negedge clk);
    chk("restart_cnt", bus.counter, 32'd0);
    @(posedge clk);
    #1;
    lat = 0;
    wait_rdy(lat);
    chk("restart_lat", lat + 1, 35);
    @(posedge clk);
    #1;
    start(1'b1, 1'b1, 32'd7, 32'hFFFFFFFD);
    wait_rdy(lat);
    chk("both_lat", lat, 19);
    chk("both_res", bus.data_result, 32'hFFFFFFEB);
    chk("both_div", 32'(bus.op_is_div), 32'd0);
    @(posedge clk);
    #1;
    start(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_res", bus.data_result, 32'd0);
    chk("rst_opa", bus.op_a, 32'd0);
    @(posedge clk);
    #1;
    start(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD);
    wait_rdy(lat);
    chk("post_rst_lat", lat, 19);
    for (int i = 0; i < 5000; i++) begin
      int r;
      @(posedge clk);
      #1;
      r = $urandom_range(0, 119);
      reset = $urandom_range(0, 399) == 0;
      bus.ctrl_MULT = r == 0 || r == 2;
      bus.ctrl_DIV = r == 1 || r == 2 || r == 3;
      bus.data_operandA = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 300);
      bus.data_operandB = $urandom_range(0, 3) == 0 ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 20));
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.ctrl_MULT = 1'b0;
    bus.ctrl_DIV = 1'b0;
    repeat (40) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Control and capture stage that sits directly upstream and downstream of the radix-4 Booth multiplier core and the iterative divider core.
- Latches operands when the pipeline issues `ctrl_MULT` or `ctrl_DIV`, and drives the shared iteration counter both cores consume.
- Samples the active core's result and error flag at the final iteration, then presents a registered result with a one-cycle ready pulse and a busy/stall signal to the processor.

Parameters:
- MULT_CYCLES, 17: counter value on which the multiplier result is valid (one load cycle plus 16 radix-4 iterations).
- DIV_CYCLES, 33: counter value on which the divider result is valid (one load cycle plus 32 iterations).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- ctrl_MULT  input  1  one-cycle start pulse for multiply.
- ctrl_DIV  input  1  one-cycle start pulse for divide.
- data_operandA  input  32  multiplicand / dividend, sampled on start.
- data_operandB  input  32  multiplier / divisor, sampled on start.
- mult_product  input  32  multiplier core product.
- mult_overflow  input  1  multiplier core overflow.
- div_quotient  input  32  divider core quotient.
- div_error  input  1  divider core error flag.
- op_a  output  32  latched operand A, routed to both cores.
- op_b  output  32  latched operand B, routed to both cores.
- counter  output  32  shared iteration counter; the cores load when bits [4:0] are 0.
- op_is_div  output  1  1 while a divide is active or captured.
- busy  output  1  high from the cycle after a start until the ready pulse; used as the pipeline stall.
- data_result  output  32  registered result.
- data_exception  output  1  registered overflow / divide-by-zero flag.
- data_resultRDY  output  1  one-cycle result-valid pulse.

Behaviour:
- Reset, synchronous and dominant over every other input; the following hold from the first cycle after the reset edge:
  - state is IDLE;
  - counter, op_a, op_b, data_result are 0;
  - data_exception, data_resultRDY, busy, op_is_div are 0.
- States:
  - IDLE: counter held at 0, busy = 0.
  - MRUN: counter increments by 1 per cycle; at counter == MULT_CYCLES, capture mult_product into data_result and mult_overflow into data_exception, then go to DONE.
  - DRUN: same as MRUN with div_quotient / div_error and DIV_CYCLES.
  - DZ: single cycle for divide by zero. data_result = 0, data_exception = 1, then go to DONE.
  - DONE: data_resultRDY = 1 for this cycle only, busy = 0, counter reset to 0; next state IDLE.
- Start:
  - If ctrl_MULT or ctrl_DIV is high in cycle t (any state), op_a and op_b latch at the end of cycle t, and counter = 0 in cycle t+1. This guarantees the core load cycle.
  - MULT: next state MRUN, op_is_div = 0.
  - DIV with data_operandB != 0: next state DRUN, op_is_div = 1.
  - DIV with data_operandB == 0: next state DZ, op_is_div = 1.
- Latency:
  - Multiply: data_resultRDY high in cycle t+MULT_CYCLES+2 (t+19 at default).
  - Divide: data_resultRDY high in cycle t+DIV_CYCLES+2 (t+35 at default).
  - Divide by zero: data_resultRDY high in cycle t+2.
- Priority rules:
  - ctrl_MULT and ctrl_DIV both high: multiply wins, divide is dropped.
  - A start while in MRUN, DRUN, DZ or DONE aborts the current operation with no ready pulse. The new operation restarts from counter 0, and op_a/op_b are overwritten.
  - Reset mid-operation aborts with no ready pulse.
- Result hold: data_result and data_exception hold their captured values until the next capture or reset. Starting a new operation does not clear them.
- counter is a plain 32-bit up-counter, never exceeding DIV_CYCLES, so bits [4:0] wrap to 0 at 32 during a divide. The multiplier output is ignored while op_is_div = 1.
- busy = 1 in MRUN, DRUN and DZ, and 0 in IDLE and DONE.
- No combinational path from any input to any output; every output is a register or decoded from state.

Test Plan:
- Multiply: A = 7, B = -3 (0xFFFFFFFD), core model returns 0xFFFFFFEB, overflow 0 → counter runs 0..17; RDY at t+19 with result 0xFFFFFFEB, exception 0; busy high t+1..t+18.
- Multiply overflow: core model asserts mult_overflow at counter 17 → data_exception = 1 and result = the core value at the RDY cycle; data_exception stays 1 until the next capture.
- Divide: A = 100, B = 7, core quotient 14 at counter 33 → RDY at t+35 with result 14, exception 0, op_is_div = 1; counter reaches 32 once, then 33.
- Divide by zero: A = 5, B = 0 → RDY at t+2 with result 0, exception 1; the divider core is never sampled.
- Restart: multiply at t, ctrl_DIV at t+8 → no RDY for the multiply; counter = 0 at t+9; divide RDY at t+8+35; simultaneous ctrl_MULT and ctrl_DIV → multiply RDY only.
- Reset at counter 10 of a multiply → all outputs 0 the next cycle, no RDY pulse; a start issued afterwards completes normally.
